// File: rtl/narma_pkg.sv
// narma_pkg: shared FSM state types, default widths and saturating-step helper for the spike-rate readout
package narma_pkg;
    typedef enum logic {CNT_IDLE, CNT_RUN} cnt_state_t;
    typedef enum logic {DR_IDLE, DR_STREAM} dr_state_t;
    localparam int DEF_CNT_W = 12;
    localparam int DEF_WIN_W = 16;
    // A counter may step only while it is below all-ones, so it saturates instead of wrapping
    function automatic logic sat_step(input logic all_ones, input logic inc);
        return inc & ~all_ones;
    endfunction
endpackage

// File: rtl/spike_counter_bank.sv
// spike_counter_bank: N_NEURONS saturating spike counters with window-end clear (or halving decay)
//   clk, rst     : clock, asynchronous active-low reset
//   i_run        : counting window active this cycle
//   i_wend       : last cycle of the window; counters clear (or halve) on the next edge
//   i_spk        : one spike bit per neuron
//   o_snap       : per-neuron count including this cycle's spike (the value captured at window end)
//   Build option : SPIKE_READOUT_DECAY_EN makes window end load o_snap>>1 instead of 0
module spike_counter_bank import narma_pkg::*; #(
    parameter int N_NEURONS = 8,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_run,
    input  logic                 i_wend,
    input  logic [N_NEURONS-1:0] i_spk,
    output logic [CNT_W-1:0]     o_snap [N_NEURONS]
);
    logic [CNT_W-1:0] r_cnt [N_NEURONS];

    always_comb
        for (int i = 0; i < N_NEURONS; i++)
            o_snap[i] = r_cnt[i] + CNT_W'(sat_step(&r_cnt[i], i_spk[i]));

    always_ff @(posedge clk or negedge rst)
        if (!rst)
            for (int i = 0; i < N_NEURONS; i++) r_cnt[i] <= '0;
        else if (i_wend)
`ifdef SPIKE_READOUT_DECAY_EN
            for (int i = 0; i < N_NEURONS; i++) r_cnt[i] <= o_snap[i] >> 1;
`else
            for (int i = 0; i < N_NEURONS; i++) r_cnt[i] <= '0;
`endif
        else if (i_run)
            for (int i = 0; i < N_NEURONS; i++) r_cnt[i] <= o_snap[i];
endmodule

// File: rtl/lif_spike_rate_readout.sv
// lif_spike_rate_readout: windowed per-neuron spike-rate counter with snapshot and valid/ready streaming
//   clk, rst            : clock, asynchronous active-low reset
//   enable              : start/continue windowed counting
//   spikes_in           : one spike bit per neuron
//   window_len          : window length in cycles (0 treated as 1), sampled at window start
//   clear_ovr           : clears the sticky overrun flag
//   out_valid/out_ready : element handshake; out_idx/out_count/out_last describe the element
//   overrun             : sticky, a window ended while the previous snapshot was still draining
//   win_done            : one-cycle pulse after each window end
//   Build option        : SPIKE_READOUT_DECAY_EN (exponential decay of live counters, see counter bank)
module lif_spike_rate_readout import narma_pkg::*; #(
    parameter int N_NEURONS = 8,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int WIN_W     = DEF_WIN_W,
    parameter int IDX_W     = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [N_NEURONS-1:0] spikes_in,
    input  logic [WIN_W-1:0]     window_len,
    input  logic                 clear_ovr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [IDX_W-1:0]     out_idx,
    output logic [CNT_W-1:0]     out_count,
    output logic                 out_last,
    output logic                 overrun,
    output logic                 win_done
);
    cnt_state_t       r_cstate;
    dr_state_t        r_dstate;
    logic [WIN_W-1:0] r_wlen, r_cyc, w_wlen_in;
    logic [IDX_W-1:0] r_idx;
    logic             r_valid, r_ovr, r_win_done;
    logic [CNT_W-1:0] r_shadow [N_NEURONS];
    logic [CNT_W-1:0] w_snap [N_NEURONS];
    logic             w_wend, w_xfer, w_last, w_accept;

    assign w_wlen_in = (window_len == '0) ? WIN_W'(1) : window_len;
    assign w_wend    = (r_cstate == CNT_RUN) && (r_cyc == r_wlen - WIN_W'(1));
    assign w_last    = r_valid && (r_idx == IDX_W'(N_NEURONS - 1));
    assign w_xfer    = r_valid && out_ready;
    // A window ending on the final transfer may take over the shadow buffer
    assign w_accept  = w_wend && (r_dstate == DR_IDLE || (w_xfer && w_last));

    spike_counter_bank #(.N_NEURONS(N_NEURONS), .CNT_W(CNT_W)) u_bank (
        .clk    (clk),
        .rst    (rst),
        .i_run  (r_cstate == CNT_RUN),
        .i_wend (w_wend),
        .i_spk  (spikes_in),
        .o_snap (w_snap)
    );

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            r_cstate   <= CNT_IDLE;
            r_wlen     <= '0;
            r_cyc      <= '0;
            r_win_done <= 1'b0;
        end else begin
            r_win_done <= w_wend;
            if (r_cstate == CNT_IDLE) begin
                if (enable) begin
                    r_cstate <= CNT_RUN;
                    r_wlen   <= w_wlen_in;
                    r_cyc    <= '0;
                end
            end else if (w_wend) begin
                r_cyc <= '0;
                if (enable) r_wlen <= w_wlen_in;
                else r_cstate <= CNT_IDLE;
            end else
                r_cyc <= r_cyc + WIN_W'(1);
        end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            r_dstate <= DR_IDLE;
            r_valid  <= 1'b0;
            r_idx    <= '0;
            r_ovr    <= 1'b0;
            for (int i = 0; i < N_NEURONS; i++) r_shadow[i] <= '0;
        end else begin
            r_ovr <= (w_wend && !w_accept) || (r_ovr && !clear_ovr);
            if (w_accept) begin
                r_shadow <= w_snap;
                r_dstate <= DR_STREAM;
                r_valid  <= 1'b1;
                r_idx    <= '0;
            end else if (w_xfer) begin
                r_idx <= w_last ? '0 : r_idx + IDX_W'(1);
                if (w_last) begin
                    r_dstate <= DR_IDLE;
                    r_valid  <= 1'b0;
                end
            end
        end

    assign out_valid = r_valid;
    assign out_idx   = r_idx;
    assign out_count = r_shadow[r_idx];
    assign out_last  = w_last;
    assign overrun   = r_ovr;
    assign win_done  = r_win_done;
endmodule

// File: doc/lif_spike_rate_readout.md
Name: lif_spike_rate_readout

Overview:
Readout stage directly downstream of the LIF neuron array.
- Counts output spikes (i_out) per neuron over a programmable window of clock cycles.
- At each window end, snapshots the counts into a shadow buffer.
- Streams the snapshot out one neuron at a time over a valid/ready handshake to the reservoir readout/regression logic.
- Counting of the next window proceeds while the previous snapshot drains.

Parameters:
N_NEURONS, 8, number of neuron spike inputs
CNT_W, 12, width of each per-neuron spike counter (saturating)
WIN_W, 16, width of the window-length input
IDX_W, 3, width of the neuron index output; must satisfy 2**IDX_W >= N_NEURONS

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
enable  in  1  start/continue windowed counting
spikes_in  in  N_NEURONS  one spike bit per neuron, sampled each clk
window_len  in  WIN_W  window length in cycles, sampled at window start; 0 treated as 1
clear_ovr  in  1  clears the sticky overrun flag
out_valid  out  1  snapshot element available
out_ready  in  1  consumer accepts the element
out_idx  out  IDX_W  neuron index of the current element
out_count  out  CNT_W  spike count of that neuron for the window
out_last  out  1  high with the element for neuron N_NEURONS-1
overrun  out  1  sticky; a window ended while the previous drain was still in progress
win_done  out  1  one-cycle pulse on each snapshot

Behaviour:
- Reset (rst low, async): counters, cycle counter, shadow buffer and outputs all 0; count FSM IDLE; drain FSM IDLE.
- Count FSM, IDLE -> COUNT:
  - Transition when enable=1 is sampled.
  - Latch wlen = max(window_len,1) and clear the cycle counter.
  - First counted cycle is the one after the transition.
- COUNT, per cycle:
  - For each i, spikes_in[i]=1 increments cnt[i], saturating at 2**CNT_W-1.
  - The cycle counter increments.
- Window end, when the cycle counter reaches wlen-1:
  - That cycle's spikes are included in the snapshot.
  - Live counters clear to 0 on the next edge.
  - win_done pulses for one cycle.
  - If enable=1: stay in COUNT, re-latch window_len, restart the cycle counter at 0.
  - If enable=0: go to IDLE.
  - Deasserting enable mid-window does not truncate the window.
- Drain FSM, IDLE -> STREAM:
  - Triggered on the cycle after a snapshot.
  - out_valid=1, out_idx=0.
- STREAM handshake:
  - A transfer occurs when out_valid & out_ready.
  - On a transfer, out_idx increments.
  - out_last=1 exactly when out_idx=N_NEURONS-1.
  - A transfer with out_last set returns to IDLE, and out_valid drops the next cycle.
  - Zero-bubble: back-to-back transfers on consecutive cycles while out_ready=1.
  - While out_valid=1 and out_ready=0: out_idx, out_count and out_last hold stable.
  - out_valid never drops without a transfer, except on reset.
- Overrun, when a window ends while the drain is not IDLE:
  - The new snapshot is discarded and the shadow buffer is unchanged.
  - The in-flight stream continues intact.
  - overrun sets, and live counters still clear.
  - A window end on the same cycle as the last transfer is not an overrun; the new snapshot is accepted.
- clear_ovr: clears overrun. If set and clear coincide, set wins.
- Latency: first element is valid 1 cycle after the window-end cycle.
- Reset mid-operation: immediate return to the reset state. out_valid falls asynchronously, and any partial stream is lost.

Optional Feature:
Macro SPIKE_READOUT_DECAY_EN.
- Defined: at window end, live counters load cnt>>1 instead of 0, giving an exponentially decaying rate trace. The snapshot still captures the full pre-shift value.
- Undefined: live counters clear to 0 at window end.
- Handshake and overrun behaviour are identical in both modes.

Decomposition:
- Shared package narma_pkg:
  - count-FSM and drain-FSM state enums (CNT_IDLE/CNT_RUN, DR_IDLE/DR_STREAM)
  - default CNT_W / WIN_W constants
  - saturating-increment function
- Sub-module spike_counter_bank: N_NEURONS saturating counters with inc, clear/decay and snapshot outputs.
- The top level holds both FSMs, the shadow buffer and the handshake.

Test Plan:
1. window_len=4; spikes_in=8'hFF for 4 cycles; out_ready=1 -> 8 elements, idx 0..7, all count=4; out_last on idx 7; first out_valid 1 cycle after the window end.
2. window_len=10; neuron 3 spikes on alternate cycles, others silent; out_ready toggles 1,0 -> count[3]=5, others 0; data held stable while ready=0; exactly 8 transfers.
3. CNT_W=4; window_len=40; neuron 0 spikes every cycle -> count[0]=15 (saturated, no wrap).
4. window_len=3; out_ready=0 across two windows -> overrun=1; stream still delivers first-window counts; clear_ovr pulse -> overrun=0.
5. enable dropped mid-window (window_len=6, drop at cycle 2) -> window completes, one snapshot, FSM IDLE, no further win_done.
6. rst low while out_valid=1 at idx 4 -> out_valid=0 immediately, overrun=0; after release with enable=0 no output. With SPIKE_READOUT_DECAY_EN and constant 8 spikes/window, window_len=8: first snapshot 8, second 12 (4+8).
